// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_HI = 4'd1,
    ADDR_LO = 4'd2,
    CNT_HI  = 4'd3,
    CNT_LO  = 4'd4,
    DATA_HI = 4'd5,
    DATA_LO = 4'd6,
    CSUM_HI = 4'd7,
    CSUM_LO = 4'd8,
    DONE    = 4'd9,
    ERROR   = 4'd10
  } loaderState_e;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // One instruction-memory word.
  typedef logic [15:0] imemWord_t;

  // Running XOR checksum over the data words of a frame.
  function automatic imemWord_t csumUpdate(input imemWord_t csum, input imemWord_t word);
    return csum ^ word;
  endfunction

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Pairs two consecutive stream bytes into a big-endian 16-bit word.
// The high byte is held in a register; the word is presented together with
// the low byte so the caller can register it in the same cycle.
module byte_pair_assembler
  import imem_loader_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      loadHi,
  input  logic      loadLo,
  input  logic [7:0] byteIn,
  output imemWord_t word,
  output logic      wordStrobe
);

  logic [7:0] hiByte_r;

  // Capture the high byte of a field when it transfers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hiByte_r <= 8'h00;
    end else if (loadHi) begin
      hiByte_r <= byteIn;
    end else begin
      hiByte_r <= hiByte_r;
    end
  end

  assign word       = {hiByte_r, byteIn};
  assign wordStrobe = loadLo;

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the instruction memory: parses a framed byte stream
// (sync, base address, word count, data words, XOR checksum), writes the
// words to consecutive addresses and releases the core on a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned MAX_WORDS = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output imemWord_t         imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  loaderState_e      state_r;
  logic              inReady_r;
  logic              imemWe_r;
  logic [ADDR_W-1:0] imemAddr_r;
  imemWord_t         imemWdata_r;
  logic              cpuHold_r;
  logic              loadDone_r;
  logic              loadErr_r;
  logic [15:0]       wordsLoaded_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       remaining_r;
  imemWord_t         csum_r;

  logic              xfer_s;
  logic              loadHi_s;
  logic              loadLo_s;
  imemWord_t         pairWord_s;
  logic              pairStrobe_s;

  // in_ready is a register driven by state transitions only, so there is no
  // path from in_valid to in_ready.
  assign xfer_s = in_valid && inReady_r;

  // Route a transferred byte to the high or low half of the current field.
  always_comb begin
    loadHi_s = 1'b0;
    loadLo_s = 1'b0;
    case (state_r)
      ADDR_HI, CNT_HI, DATA_HI, CSUM_HI: loadHi_s = xfer_s;
      ADDR_LO, CNT_LO, DATA_LO, CSUM_LO: loadLo_s = xfer_s;
      default: begin
        loadHi_s = 1'b0;
        loadLo_s = 1'b0;
      end
    endcase
  end

  byte_pair_assembler uPair (
    .clk        (clk),
    .reset      (reset),
    .loadHi     (loadHi_s),
    .loadLo     (loadLo_s),
    .byteIn     (in_data),
    .word       (pairWord_s),
    .wordStrobe (pairStrobe_s)
  );

  // Frame FSM with address counter, checksum and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      inReady_r     <= 1'b0;
      imemWe_r      <= 1'b0;
      imemAddr_r    <= '0;
      imemWdata_r   <= 16'h0000;
      cpuHold_r     <= 1'b1;
      loadDone_r    <= 1'b0;
      loadErr_r     <= 1'b0;
      wordsLoaded_r <= 16'd0;
      addr_r        <= '0;
      remaining_r   <= 16'd0;
      csum_r        <= 16'h0000;
    end else begin
      imemWe_r <= 1'b0;
      case (state_r)
        IDLE: begin
          inReady_r <= 1'b1;
          if (xfer_s && (in_data == SYNC_BYTE)) begin
            state_r <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (xfer_s) begin
            state_r <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (pairStrobe_s) begin
            addr_r  <= ADDR_W'(pairWord_s);
            state_r <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (xfer_s) begin
            state_r <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (pairStrobe_s) begin
            remaining_r <= pairWord_s;
            if (32'(pairWord_s) > MAX_WORDS) begin
              state_r   <= ERROR;
              inReady_r <= 1'b0;
              loadErr_r <= 1'b1;
            end else if (pairWord_s == 16'd0) begin
              state_r <= CSUM_HI;
            end else begin
              state_r <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (xfer_s) begin
            state_r <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (pairStrobe_s) begin
            imemWe_r      <= 1'b1;
            imemAddr_r    <= addr_r;
            imemWdata_r   <= pairWord_s;
            csum_r        <= csumUpdate(csum_r, pairWord_s);
            addr_r        <= addr_r + ADDR_W'(1);
            wordsLoaded_r <= wordsLoaded_r + 16'd1;
            remaining_r   <= remaining_r - 16'd1;
            if (remaining_r == 16'd1) begin
              state_r <= CSUM_HI;
            end else begin
              state_r <= DATA_HI;
            end
          end
        end
        CSUM_HI: begin
          if (xfer_s) begin
            state_r <= CSUM_LO;
          end
        end
        CSUM_LO: begin
          if (pairStrobe_s) begin
            inReady_r <= 1'b0;
            if (pairWord_s == csum_r) begin
              state_r    <= DONE;
              loadDone_r <= 1'b1;
              cpuHold_r  <= 1'b0;
            end else begin
              state_r   <= ERROR;
              loadErr_r <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          inReady_r <= 1'b0;
          if (start) begin
            state_r       <= IDLE;
            inReady_r     <= 1'b1;
            cpuHold_r     <= 1'b1;
            loadDone_r    <= 1'b0;
            loadErr_r     <= 1'b0;
            wordsLoaded_r <= 16'd0;
            csum_r        <= 16'h0000;
          end
        end
        default: begin
          state_r   <= IDLE;
          inReady_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = inReady_r;
  assign imem_we      = imemWe_r;
  assign imem_addr    = imemAddr_r;
  assign imem_wdata   = imemWdata_r;
  assign cpu_hold     = cpuHold_r;
  assign load_done    = loadDone_r;
  assign load_err     = loadErr_r;
  assign words_loaded = wordsLoaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares every imem_we cycle.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [31:0] expQ[$];
  logic [7:0]  frameQ[$];
  logic [31:0] monExp;

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .start        (start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write cycle must match the next expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        monExp = expQ.pop_front();
        check("write_addr", {16'd0, imem_addr}, {16'd0, monExp[31:16]});
        check("write_data", {16'd0, imem_wdata}, {16'd0, monExp[15:0]});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input int maxGap, input bit pokeStart);
    foreach (frameQ[i]) begin
      if (pokeStart && (i == 3 || i == 7)) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      sendByte(frameQ[i]);
      if (maxGap > 0) repeat ($urandom_range(maxGap, 0)) @(negedge clk);
    end
  endtask

  task automatic checkFlags(input string tag, input logic done, input logic err,
                            input logic hold, input logic [15:0] words);
    check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, words});
  endtask

  task automatic pulseStart(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkFlags(tag, 1'b0, 1'b0, 1'b1, 16'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic checkDrained(input string tag);
    check({tag, "_pending_writes"}, expQ.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {16'd0, imem_addr}, 32'd0);
    checkFlags("rst", 1'b0, 1'b0, 1'b1, 16'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Two-word frame, good checksum 1234^ABCD = B9F9
    frameQ = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hB9, 8'hF9};
    expQ.push_back({16'h0010, 16'h1234});
    expQ.push_back({16'h0011, 16'hABCD});
    sendFrame(0, 1'b0);
    checkFlags("good", 1'b1, 1'b0, 1'b0, 16'd2);
    check("good_in_ready", {31'd0, in_ready}, 32'd0);
    checkDrained("good");
    pulseStart("good_restart");

    // Same frame, bad checksum
    frameQ = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
    expQ.push_back({16'h0010, 16'h1234});
    expQ.push_back({16'h0011, 16'hABCD});
    sendFrame(0, 1'b0);
    checkFlags("badcsum", 1'b0, 1'b1, 1'b1, 16'd2);
    checkDrained("badcsum");
    pulseStart("err_restart");

    // Junk before sync, zero-count frame
    frameQ = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    sendFrame(0, 1'b0);
    checkFlags("empty", 1'b1, 1'b0, 1'b0, 16'd0);
    checkDrained("empty");
    pulseStart("empty_restart");

    // Address wrap at 0xFFFF, checksum 0001^0002 = 0003
    frameQ = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    expQ.push_back({16'hFFFF, 16'h0001});
    expQ.push_back({16'h0000, 16'h0002});
    sendFrame(0, 1'b0);
    checkFlags("wrap", 1'b1, 1'b0, 1'b0, 16'd2);
    checkDrained("wrap");
    pulseStart("wrap_restart");

    // Reset after DATA_HI of the second word: that word is never written
    frameQ = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    expQ.push_back({16'h0010, 16'h1234});
    sendFrame(0, 1'b0);
    in_data  = 8'hCD;
    in_valid = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    check("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    check("midrst_imem_addr", {16'd0, imem_addr}, 32'd0);
    check("midrst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    checkFlags("midrst", 1'b0, 1'b0, 1'b1, 16'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_recover_in_ready", {31'd0, in_ready}, 32'd1);
    checkDrained("midrst");
    frameQ = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hB9, 8'hF9};
    expQ.push_back({16'h0010, 16'h1234});
    expQ.push_back({16'h0011, 16'hABCD});
    sendFrame(0, 1'b0);
    checkFlags("after_rst", 1'b1, 1'b0, 1'b0, 16'd2);
    checkDrained("after_rst");
    pulseStart("after_rst_restart");

    // Gapped stream with start pulses mid-frame (ignored)
    expQ.push_back({16'h0010, 16'h1234});
    expQ.push_back({16'h0011, 16'hABCD});
    sendFrame(3, 1'b1);
    checkFlags("gapped", 1'b1, 1'b0, 1'b0, 16'd2);
    checkDrained("gapped");

    // In DONE, a pending byte is never accepted
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_in_ready", {31'd0, in_ready}, 32'd0);
      check("done_hold", {31'd0, load_done}, 32'd1);
    end
    in_valid = 1'b0;
    pulseStart("final_restart");
    repeat (2) @(negedge clk);
    checkDrained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's 16-bit instruction memory. It is the write side of the port that the fetch stage only reads.
- Consumes a framed byte stream over a valid/ready handshake, assembles the bytes into 16-bit words, and writes them to consecutive instruction-memory addresses.
- Checks an XOR checksum at the end of the frame.
- Holds the core in reset (cpu_hold) until a frame loads cleanly.
- Sits beside the core top level, between the host/UART byte source and the instruction-memory write port.

Parameters:
- ADDR_W, 16, width of the instruction-memory word address.
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_WORDS, 65535, largest legal word count. A larger count is a frame error.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-low; all state updates on clk when reset==0.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the byte this cycle.
- start  input  1  single-cycle pulse: re-arm the loader from DONE/ERROR.
- imem_we  output  1  instruction-memory write enable, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  16  word written.
- cpu_hold  output  1  keeps the core in reset while 1.
- load_done  output  1  level: last frame loaded and checksum matched.
- load_err  output  1  level: last frame failed (checksum mismatch or count > MAX_WORDS).
- words_loaded  output  16  number of words written in the current or last frame.

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state=IDLE
  - in_ready=0 during reset, 1 from the first cycle after it
  - imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, load_done=0, load_err=0, words_loaded=0
  - internal checksum/count=0
  - An in-progress frame is abandoned and no write occurs in the reset cycle.
- A byte transfers only on a cycle with in_valid && in_ready.
- in_ready=1 in IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO. in_ready=0 in DONE and ERROR.
- All multi-byte fields are big-endian (high byte first).
- States and transitions, each advancing on a transferred byte:
  - IDLE: byte==SYNC_BYTE -> ADDR_HI; any other byte is discarded.
  - ADDR_HI -> ADDR_LO. Base address = {hi,lo}, truncated or zero-extended to ADDR_W.
  - CNT_HI -> CNT_LO. The count is checked on the CNT_LO byte:
    - count > MAX_WORDS -> ERROR
    - count==0 -> CSUM_HI
    - otherwise -> DATA_HI
  - DATA_HI: latch the high byte -> DATA_LO.
  - DATA_LO: in the same cycle, register imem_we=1, imem_wdata={hi,lo}, imem_addr=current address.
    - The write is visible on the outputs the next cycle, for exactly one cycle.
    - checksum ^= word; address += 1 modulo 2^ADDR_W (wraps silently); words_loaded += 1.
    - If this was the last word -> CSUM_HI, else -> DATA_HI.
  - CSUM_HI -> CSUM_LO. On the CSUM_LO byte, compare {hi,lo} with the running checksum:
    - equal -> DONE
    - not equal -> ERROR
  - DONE: load_done=1, cpu_hold=0 from the cycle after entry.
  - ERROR: load_err=1, cpu_hold stays 1.
  - start in DONE or ERROR:
    - next cycle state=IDLE, cpu_hold=1, load_done=0, load_err=0, words_loaded=0, checksum=0
    - start in any other state is ignored.
  - start together with in_valid in DONE/ERROR: no byte is accepted (in_ready=0), and start wins.
- Words already written before an ERROR stay in memory. There is no rollback.
- words_loaded counts modulo 2^16.
- No combinational path from in_valid to in_ready; in_ready depends on state only.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERROR)
  - SYNC_BYTE default
  - the 16-bit word typedef used by the instruction-memory port
- One natural sub-module, byte_pair_assembler: latches the high byte and emits the 16-bit word plus a strobe on the low byte. It is reused for address, count, data and checksum fields.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Reset, then frame A5 00 10 00 02 12 34 AB CD B9 F9 -> writes:
  - addr 0x0010=0x1234, then addr 0x0011=0xABCD, each imem_we one cycle
  - load_done=1, cpu_hold=0, words_loaded=2
- Same frame with checksum 00 00 -> both words written, then load_err=1, cpu_hold=1, load_done=0. A start pulse returns to IDLE with the flags cleared.
- Junk bytes 00 FF 5A before A5, count 0, checksum 00 00 -> the junk is discarded, no imem_we, load_done=1, words_loaded=0.
- Base address 0xFFFF, 2 words 0001 0002, checksum 00 03 -> writes at 0xFFFF then 0x0000 (wrap), load_done=1.
- Drop reset (reset=0) for one cycle after DATA_HI of the 2nd word -> no write that cycle, outputs at reset values. A fresh frame afterwards loads correctly.
- in_valid toggling randomly with gaps, and start asserted mid-frame -> data identical to the gap-free case, start ignored. In DONE with in_valid=1, in_ready stays 0.
